// File: rtl/ssd_mux_driver.sv
// Multiplexed 7-segment driver: BCD shadow registers, refresh prescaler,
// per-slot decode with leading-zero blanking and frame pulse.
module ssd_mux_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_bcd;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    wrap;
  logic                    wrap_q;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    run;
  logic [3:0]              cur;
  logic                    cur_dp;
  logic                    cur_lz;
  logic [6:0]              dec;

  assign wrap = (presc == PMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      idx    <= '0;
      sh_bcd <= '1;
      sh_dp  <= '0;
      wrap_q <= 1'b0;
    end else begin
      presc  <= wrap ? '0 : presc + PW'(1);
      if (wrap)
        idx <= (idx == IMAX) ? '0 : idx + IW'(1);
      if (load) begin
        sh_bcd <= bcd_in;
        sh_dp  <= dp_in;
      end
      wrap_q <= wrap && (idx == IMAX);
    end
  end

  // lz[i]: digit i and everything above it is a bare zero
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run && (sh_bcd[4*i +: 4] == 4'd0) && !sh_dp[i];
      lz[i] = run;
    end
    lz[0] = 1'b0;
  end

  assign cur    = sh_bcd[4*idx +: 4];
  assign cur_dp = sh_dp[idx];
  assign cur_lz = LZ_BLANK && lz[idx];

  always_comb begin
    dec = 7'b1111111;
    unique case (cur)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      seg <= 7'b1111111;
      dp  <= 1'b1;
      AN  <= '1;
    end else begin
      seg <= cur_lz ? 7'b1111111 : dec;
      dp  <= ~cur_dp;
      AN  <= ~(NUM_DIGITS'(1) << idx);
    end
    frame_done <= rst ? 1'b0 : wrap_q;
  end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed bench for ssd_mux_driver: vector table for decode/blanking
// plus hand sequences for refresh timing, enable, load-on-wrap and reset.
module tb_ssd_mux_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b1;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0] seg, seg0, seg1;
  logic       dp, dp0, dp1;
  logic [3:0] an, an0;
  logic [0:0] an1;
  logic       fd, fd0, fd1;

  always #5 clk = ~clk;

  ssd_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_CYCLES(4), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .dp_in(dp_in), .en(en), .seg(seg), .dp(dp), .AN(an),
    .frame_done(fd)
  );

  ssd_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_CYCLES(4), .LZ_BLANK(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .dp_in(dp_in), .en(en), .seg(seg0), .dp(dp0), .AN(an0),
    .frame_done(fd0)
  );

  ssd_mux_driver #(
    .NUM_DIGITS(1), .REFRESH_CYCLES(4), .LZ_BLANK(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in[3:0]),
    .dp_in(dp_in[0:0]), .en(en), .seg(seg1), .dp(dp1), .AN(an1),
    .frame_done(fd1)
  );

  int tests = 0;
  int fails = 0;
  int k = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    int          slot;
    logic [6:0]  s1;
    logic [6:0]  s0;
    logic        d;
  } vec_t;

  vec_t tv [24];
  logic [6:0] s1234 [4];

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    en   = 1'b1;
    step();
    step();
    rst = 1'b0;
    k   = 0;
  endtask

  function automatic logic [3:0] an_of(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  initial begin
    tv[0]  = '{16'h1234, 4'b0100, 0, 7'b0011001, 7'b0011001, 1'b1};
    tv[1]  = '{16'h1234, 4'b0100, 1, 7'b0110000, 7'b0110000, 1'b1};
    tv[2]  = '{16'h1234, 4'b0100, 2, 7'b0100100, 7'b0100100, 1'b0};
    tv[3]  = '{16'h1234, 4'b0100, 3, 7'b1111001, 7'b1111001, 1'b1};
    tv[4]  = '{16'h0070, 4'b0000, 0, 7'b1000000, 7'b1000000, 1'b1};
    tv[5]  = '{16'h0070, 4'b0000, 1, 7'b1111000, 7'b1111000, 1'b1};
    tv[6]  = '{16'h0070, 4'b0000, 2, 7'b1111111, 7'b1000000, 1'b1};
    tv[7]  = '{16'h0070, 4'b0000, 3, 7'b1111111, 7'b1000000, 1'b1};
    tv[8]  = '{16'h0000, 4'b0000, 0, 7'b1000000, 7'b1000000, 1'b1};
    tv[9]  = '{16'h0000, 4'b0000, 1, 7'b1111111, 7'b1000000, 1'b1};
    tv[10] = '{16'h0000, 4'b0010, 1, 7'b1000000, 7'b1000000, 1'b0};
    tv[11] = '{16'h0000, 4'b0010, 2, 7'b1111111, 7'b1000000, 1'b1};
    tv[12] = '{16'h0000, 4'b0010, 3, 7'b1111111, 7'b1000000, 1'b1};
    tv[13] = '{16'h0A05, 4'b0000, 1, 7'b1000000, 7'b1000000, 1'b1};
    tv[14] = '{16'h0A05, 4'b0000, 2, 7'b1111111, 7'b1111111, 1'b1};
    tv[15] = '{16'h0A05, 4'b0000, 3, 7'b1111111, 7'b1000000, 1'b1};
    tv[16] = '{16'h5678, 4'b0000, 0, 7'b0000000, 7'b0000000, 1'b1};
    tv[17] = '{16'h5678, 4'b0000, 1, 7'b1111000, 7'b1111000, 1'b1};
    tv[18] = '{16'h5678, 4'b0000, 2, 7'b0000010, 7'b0000010, 1'b1};
    tv[19] = '{16'h5678, 4'b0000, 3, 7'b0010010, 7'b0010010, 1'b1};
    tv[20] = '{16'h90BC, 4'b0000, 0, 7'b1111111, 7'b1111111, 1'b1};
    tv[21] = '{16'h90BC, 4'b0000, 1, 7'b1111111, 7'b1111111, 1'b1};
    tv[22] = '{16'h90BC, 4'b0000, 2, 7'b1000000, 7'b1000000, 1'b1};
    tv[23] = '{16'h90BC, 4'b0000, 3, 7'b0010000, 7'b0010000, 1'b1};
    s1234  = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    // reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_fd", 32'(fd), 32'h0);
    chk("rst_an1", 32'(an1), 32'h1);
    rst = 1'b0;
    k   = 0;

    // free run after reset, no load
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("run_an", 32'(an), 32'(an_of(((k - 1) / 4) % 4)));
      chk("run_an0", 32'(an0), 32'(an_of(((k - 1) / 4) % 4)));
      chk("run_seg", 32'(seg), 32'h7F);
      chk("run_dp", 32'(dp), 32'h1);
      chk("run_fd", 32'(fd), 32'(k >= 17 && ((k - 1) % 16) == 0));
      chk("run_fd0", 32'(fd0), 32'(k >= 17 && ((k - 1) % 16) == 0));
      chk("run1_an", 32'(an1), 32'h0);
      chk("run1_seg", 32'(seg1), 32'h7F);
      chk("run1_dp", 32'(dp1), 32'h1);
      chk("run1_fd", 32'(fd1), 32'(k >= 5 && ((k - 1) % 4) == 0));
    end

    // decode / blanking table
    foreach (tv[v]) begin
      do_reset();
      bcd_in = tv[v].bcd;
      dp_in  = tv[v].dpv;
      load   = 1'b1;
      step();
      load = 1'b0;
      while (k < 4 * tv[v].slot + 3) step();
      chk($sformatf("vec%0d_seg", v), 32'(seg), 32'(tv[v].s1));
      chk($sformatf("vec%0d_seg_nolz", v), 32'(seg0), 32'(tv[v].s0));
      chk($sformatf("vec%0d_dp", v), 32'(dp), 32'(tv[v].d));
      chk($sformatf("vec%0d_dp_nolz", v), 32'(dp0), 32'(tv[v].d));
      chk($sformatf("vec%0d_an", v), 32'(an), 32'(an_of(tv[v].slot)));
    end

    // enable dropped for 10 cycles mid-frame
    do_reset();
    bcd_in = 16'h1234;
    dp_in  = 4'b0000;
    load   = 1'b1;
    step();
    load = 1'b0;
    while (k < 6) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("dis_an", 32'(an), 32'hF);
      chk("dis_seg", 32'(seg), 32'h7F);
      chk("dis_dp", 32'(dp), 32'h1);
    end
    en = 1'b1;
    step();
    chk("reen_an", 32'(an), 32'hE);
    chk("reen_seg", 32'(seg), 32'(7'b0011001));
    chk("reen_fd", 32'(fd), 32'h1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("reen_run_an", 32'(an), 32'(an_of(((k - 1) / 4) % 4)));
      chk("reen_run_seg", 32'(seg), 32'(s1234[((k - 1) / 4) % 4]));
    end

    // load on the wrap edge, then load held for three edges
    do_reset();
    bcd_in = 16'h1234;
    dp_in  = 4'b0000;
    load   = 1'b1;
    step();
    load = 1'b0;
    while (k < 3) step();
    bcd_in = 16'h12A9;
    load   = 1'b1;
    step();
    load = 1'b0;
    chk("wrap_old_seg", 32'(seg), 32'(7'b0011001));
    chk("wrap_old_an", 32'(an), 32'hE);
    step();
    chk("wrap_new_seg", 32'(seg), 32'h7F);
    chk("wrap_new_an", 32'(an), 32'hD);
    chk("wrap_new_dp", 32'(dp), 32'h1);
    while (k < 7) step();
    load   = 1'b1;
    bcd_in = 16'h1111;
    step();
    bcd_in = 16'h2222;
    step();
    bcd_in = 16'h5678;
    step();
    load = 1'b0;
    chk("hold_mid_seg", 32'(seg), 32'(7'b0100100));
    step();
    step();
    chk("hold_last_seg2", 32'(seg), 32'(7'b0000010));
    chk("hold_last_an2", 32'(an), 32'hB);
    step();
    chk("hold_last_seg3", 32'(seg), 32'(7'b0010010));
    chk("hold_last_an3", 32'(an), 32'h7);

    // reset while slot 2 is showing, with load asserted alongside
    do_reset();
    bcd_in = 16'h1234;
    dp_in  = 4'b0100;
    load   = 1'b1;
    step();
    load = 1'b0;
    while (k < 10) step();
    chk("pre_rst_seg", 32'(seg), 32'(7'b0100100));
    chk("pre_rst_dp", 32'(dp), 32'h0);
    rst    = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h5555;
    step();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'h1);
    chk("mid_rst_fd", 32'(fd), 32'h0);
    rst  = 1'b0;
    load = 1'b0;
    k    = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_an", 32'(an), 32'(an_of(((k - 1) / 4) % 4)));
      chk("post_rst_seg", 32'(seg), 32'h7F);
      chk("post_rst_dp", 32'(dp), 32'h1);
      chk("post_rst_fd", 32'(fd), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_mux_driver.md
SSD_MUX_DRIVER -- requirements
Module: ssd_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 Parameter REFRESH_CYCLES, default 100000, clock cycles per digit slot (legal >= 2).
REQ-003 Parameter LZ_BLANK, default 1, leading-zero blanking enable (1 = on, 0 = off).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 load  input  1  one-cycle strobe that captures bcd_in and dp_in.
REQ-007 bcd_in  input  4*NUM_DIGITS  digit i on bits [4i+3:4i]; digit 0 is rightmost.
REQ-008 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 en  input  1  display enable, 1 = drive, 0 = dark.
REQ-010 seg  output  7  segments g..a on seg[6:0], active-low (common anode), registered.
REQ-011 dp  output  1  decimal point, active-low, registered.
REQ-012 AN  output  NUM_DIGITS  digit anodes, active-low, one-hot-low, registered.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full refresh frame.

Function
REQ-014 Shadow registers SHALL capture bcd_in and dp_in on any clk edge where load=1; otherwise they hold.
REQ-015 Prescaler SHALL count 0..REFRESH_CYCLES-1 and then wrap to 0.
REQ-016 Digit index idx SHALL increment when the prescaler wraps, wrapping NUM_DIGITS-1 -> 0.
REQ-017 Outputs SHALL be registered from current shadow and idx: 1-cycle latency from any idx or shadow change to seg/dp/AN.
REQ-018 AN SHALL be all ones except bit idx = 0.
REQ-019 Decode of shadow digit idx into seg SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- codes 10..15 = 1111111 (blank)
REQ-020 dp SHALL equal ~shadow_dp[idx].
REQ-021 With LZ_BLANK=1, digit i>0 SHALL show seg=1111111 when digit i and all higher digits are 0 and none of their dp bits is set.
REQ-022 Digit 0 SHALL never be leading-zero blanked.
REQ-023 With LZ_BLANK=0, zeros SHALL always display as 1000000.
REQ-024 With en=0, registered outputs SHALL be seg=1111111, dp=1, AN all ones.
REQ-025 Prescaler and idx SHALL keep running while en=0; re-enable resumes at the current idx without resync.
REQ-026 frame_done SHALL be 1 for exactly the cycle after the prescaler wraps with idx=NUM_DIGITS-1, and 0 otherwise (1-cycle latency, aligned with the AN change to digit 0).
REQ-027 load coinciding with a prescaler wrap: both take effect on that edge; the new slot SHALL display the newly loaded value.
REQ-028 load held high across several cycles: the last captured value wins; no other side effects.
REQ-029 NUM_DIGITS=1: idx SHALL stay 0, AN=0 whenever en=1, and frame_done SHALL pulse once per REFRESH_CYCLES.

Reset
REQ-030 While rst=1 at an edge: prescaler=0, idx=0, shadow bcd all 4'hF, shadow dp all 0.
REQ-031 Outputs registered during reset: seg=1111111, dp=1, AN all ones, frame_done=0.
REQ-032 rst SHALL override load and en on the same edge.
REQ-033 First cycle after rst deasserts: idx=0, prescaler begins counting from 0.
REQ-034 Reset mid-frame SHALL restart at digit 0 with blank content.

Verification (NUM_DIGITS=4, REFRESH_CYCLES=4 unless stated)
REQ-035 Bench SHALL cover the following scenarios:
- Reset release, no load -> AN cycles 1110, 1101, 1011, 0111, each held 4 cycles; seg=1111111 throughout; frame_done pulses every 16 cycles.
- load bcd_in=16'h1234, dp_in=4'b0100, en=1 -> slot 0 seg=0011001; slot 1 seg=0110000; slot 2 seg=0100100 with dp=0; slot 3 seg=1111001.
- LZ_BLANK=1, load 16'h0070 -> slots 3 and 2 blank, slot 1 =1111000, slot 0 =1000000; with LZ_BLANK=0, slots 3 and 2 =1000000.
- en deasserted for 10 cycles mid-frame -> AN=1111 and seg=1111111 one cycle later; on re-enable, AN matches the idx implied by continuous counting.
- load asserted on the prescaler-wrap edge -> the next digit shows the new value with 1-cycle latency; values above 9 (e.g. 4'hA) decode to 1111111.
- rst asserted while slot 2 is active -> next cycle AN=1111, seg=1111111; after release, AN=1110 and shadow is blank.
